readout_scheduler: RTL and testbench
====================================

# readout_scheduler

Sequences the row-by-row readout of the pixel array after exposure. It drives the active-low row selects, issues one ADC conversion per row with a settle delay and a conversion timeout, and hands each digitized pixel downstream over a valid/ready handshake. It sits between the exposure/readout state control, which pulses `start` when exposure ends, and the pixel store/display path. It owns the single shared ADC for the whole frame.

## Interface
Parameters:
- `ROWS`, default 2: rows per frame, range 2–16.
- `DW`, default 4: ADC and pixel data width.
- `SETTLE`, default 1: cycles a row select is held low before `adc_start`, minimum 1.
- `TIMEOUT`, default 15: maximum cycles spent waiting for `adc_done`, minimum 2.

Ports:
- `clk`  in  1: clock. All logic is on the rising edge.
- `reset`  in  1: asynchronous, active-high.
- `start`  in  1: begin a frame readout. Sampled only in IDLE.
- `abort`  in  1: cancel any readout in progress.
- `nre`  out  ROWS: active-low row selects. At most one bit is low at any time.
- `adc_start`  out  1: one-cycle conversion request.
- `adc_done`  in  1: conversion complete. `adc_data` is valid in the same cycle.
- `adc_data`  in  DW: conversion result.
- `px_valid`  out  1: `px_data`/`px_row` are valid.
- `px_ready`  in  1: downstream accepts the pixel.
- `px_data`  out  DW: captured pixel value.
- `px_row`  out  clog2(ROWS): row index of `px_data`.
- `busy`  out  1: state != IDLE (decoded from the state register).
- `frame_done`  out  1: one-cycle pulse at the end of a frame.
- `timeout_err`  out  1: sticky ADC timeout flag.
- `frame_cnt`  out  8: count of completed frames. Wraps 255→0.

## Operation
- Reset values: `nre` all 1; `adc_start`, `px_valid`, `frame_done`, `timeout_err` = 0; `px_data`, `px_row`, `frame_cnt` = 0; state = IDLE.
- Every output except `busy` is registered.
- States: IDLE, SELECT, CONVERT, OUTPUT, GAP, DONE.
- IDLE: when `start`=1, set row=0, drive `nre[0]`=0, clear `timeout_err`, go to SELECT.
- SELECT: hold the row for SETTLE cycles. On the last cycle, drive `adc_start`=1 for one cycle, clear the timer, go to CONVERT.
- CONVERT:
  - On `adc_done`: `px_data`←`adc_data`, `px_row`←row, `px_valid`←1, go to OUTPUT.
  - Otherwise the timer increments. If the timer reaches TIMEOUT-1 with no `adc_done`: `timeout_err`←1, `nre` all 1, go to DONE. The frame is truncated and no pixel is emitted for that row.
- OUTPUT: hold `px_valid`, `px_data` and `px_row` stable until `px_ready`=1. On that edge: `px_valid`←0, `nre[row]`←1, go to GAP.
- GAP: one cycle with all `nre`=1.
  - If row==ROWS-1, go to DONE.
  - Otherwise row+1, drive `nre[row+1]`=0, go to SELECT.
- DONE: `frame_done`=1 for one cycle, `frame_cnt`+1, then IDLE. A timeout-terminated frame still pulses `frame_done` and counts.
- `abort`=1 in any state other than IDLE: the next edge forces IDLE, `nre` all 1, `adc_start`/`px_valid` 0. No `frame_done` pulse, `frame_cnt` unchanged, `timeout_err` retained.
- Simultaneous events:
  - `abort` beats everything, including `start` in IDLE: abort in IDLE is a no-op, and `start` in the same cycle is ignored.
  - `adc_done` beats the timeout on the final CONVERT cycle.
- `start` outside IDLE is ignored (not queued).
- `adc_done` outside CONVERT is ignored.
- `px_ready` outside OUTPUT is ignored.
- `reset` at any time, including mid-frame, returns every output to its reset value immediately.

## Timing
- Per-row cost: SETTLE + 3 + (ADC latency − 1) + (`px_ready` stall) cycles.
- Reference case: SETTLE=1, `adc_done` in the cycle after `adc_start`, `px_ready` tied high. Edge numbers count from the edge that samples `start` (edge 0):
  - Edge 0: `nre[0]`=0.
  - Edge 1: `adc_start`=1.
  - Edge 2: `px_valid`=1.
  - Edge 3: GAP.
  - Edge 4: `nre[1]`=0.
  - Edge 5: `adc_start`.
  - Edge 6: `px_valid`.
  - Edge 7: GAP.
  - Edge 8: `frame_done`=1.
  - Edge 9: IDLE, `busy`=0.
- `adc_start` is exactly one cycle per row.
- `nre` transitions occur only at state entry and exit, never two bits low at once, and there is at least one all-high cycle between rows.

## Test plan
- Nominal frame (defaults, `px_ready`=1, `adc_data` = 4'h3 then 4'hC) → pixels (row0,3) then (row1,C). `frame_done` at edge 8, `frame_cnt`=1, `timeout_err`=0.
- Backpressure: hold `px_ready`=0 for 5 cycles in row 0 OUTPUT → `px_valid`, `px_data` and `nre[0]`=0 are stable throughout. The row advances one edge after `px_ready` rises.
- ADC timeout: never assert `adc_done` → after 15 CONVERT cycles `timeout_err`=1, `nre`=2'b11, `frame_done` pulses, and no `px_valid` is seen. The next `start` clears `timeout_err`.
- `adc_done` on the final timeout cycle → the pixel is accepted and `timeout_err` stays 0.
- `abort` during row 1 SELECT → IDLE at the next edge, `nre` all high, no `frame_done`, `frame_cnt` unchanged. `start` in the same cycle as `abort` in IDLE → stays IDLE.
- Async `reset` mid-CONVERT → all outputs reset without a clock edge. Also run 256 nominal frames → `frame_cnt` wraps to 0.

Source files
------------

// File: rtl/readout_scheduler.sv
// -----------------------------------------------------------------------------
// readout_scheduler
//
// Sequences the row-by-row readout of the pixel array once exposure ends.
// For each row it pulls the active-low row select low and waits SETTLE cycles.
// It then issues a single adc_start pulse and waits for adc_done, giving up
// after TIMEOUT cycles. The captured pixel goes downstream on a valid/ready
// handshake. After that handshake the row select is released for one all-high
// GAP cycle before the next row starts.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   start        in   begin a frame (sampled only in IDLE)
//   abort        in   cancel the readout in progress (beats everything)
//   nre          out  [ROWS]  active-low row selects, at most one bit low
//   adc_start    out  one-cycle conversion request
//   adc_done     in   conversion complete, adc_data valid in the same cycle
//   adc_data     in   [DW]    conversion result
//   px_valid     out  px_data / px_row valid
//   px_ready     in   downstream accepts the pixel
//   px_data      out  [DW]    captured pixel value
//   px_row       out  [clog2(ROWS)] row index of px_data
//   busy         out  scheduler is not IDLE (decoded from the state register)
//   frame_done   out  one-cycle pulse while in DONE
//   timeout_err  out  sticky ADC timeout flag, cleared by the next start
//   frame_cnt    out  [8] completed frames, wraps 255 -> 0
// -----------------------------------------------------------------------------
module readout_scheduler #(
  parameter int ROWS    = 2,
  parameter int DW      = 4,
  parameter int SETTLE  = 1,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  output logic [ROWS-1:0]           nre,
  output logic                      adc_start,
  input  logic                      adc_done,
  input  logic [DW-1:0]             adc_data,
  output logic                      px_valid,
  input  logic                      px_ready,
  output logic [DW-1:0]             px_data,
  output logic [$clog2(ROWS)-1:0]   px_row,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      timeout_err,
  output logic [7:0]                frame_cnt
);

  localparam int RW = $clog2(ROWS);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [RW-1:0]   ROW_LAST    = RW'(ROWS - 1);
  localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [TW-1:0]   TIMER_LAST  = TW'(TIMEOUT - 1);
  localparam logic [ROWS-1:0] ALL_HIGH    = {ROWS{1'b1}};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SELECT  = 3'd1,
    CONVERT = 3'd2,
    OUTPUT  = 3'd3,
    GAP     = 3'd4,
    DONE    = 3'd5
  } state_t;

  // Active-low select pattern with only the given row pulled low, so the
  // one-low-at-a-time property holds by construction.
  function automatic logic [ROWS-1:0] row_select(input logic [RW-1:0] r);
    logic [ROWS-1:0] one_hot;
    one_hot = {{(ROWS-1){1'b0}}, 1'b1} << r;
    return ~one_hot;
  endfunction

  state_t            state_r;
  state_t            state_s;
  logic [RW-1:0]     row_r;
  logic [RW-1:0]     row_s;
  logic [SW-1:0]     settle_r;
  logic [SW-1:0]     settle_s;
  logic [TW-1:0]     timer_r;
  logic [TW-1:0]     timer_s;

  logic [ROWS-1:0]   nre_s;
  logic              adc_start_s;
  logic              px_valid_s;
  logic [DW-1:0]     px_data_s;
  logic [RW-1:0]     px_row_s;
  logic              frame_done_s;
  logic              timeout_err_s;
  logic [7:0]        frame_cnt_s;

  // busy is the only output decoded directly from the state register.
  assign busy = (state_r != IDLE);

  // Next-state and next-output decode; every register holds unless changed.
  always_comb begin
    state_s       = state_r;
    row_s         = row_r;
    settle_s      = settle_r;
    timer_s       = timer_r;
    nre_s         = nre;
    adc_start_s   = 1'b0;
    px_valid_s    = px_valid;
    px_data_s     = px_data;
    px_row_s      = px_row;
    frame_done_s  = 1'b0;
    timeout_err_s = timeout_err;
    frame_cnt_s   = frame_cnt;

    if (abort && (state_r != IDLE)) begin
      // Cancel: release the array and drop the handshake. The frame is not
      // counted and any timeout flag is kept for software to inspect.
      state_s    = IDLE;
      nre_s      = ALL_HIGH;
      px_valid_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          // abort in the same cycle suppresses start even though it is a no-op here
          if (start && !abort) begin
            row_s         = {RW{1'b0}};
            settle_s      = {SW{1'b0}};
            nre_s         = row_select({RW{1'b0}});
            timeout_err_s = 1'b0;
            state_s       = SELECT;
          end else begin
            state_s = IDLE;
          end
        end

        SELECT: begin
          if (settle_r == SETTLE_LAST) begin
            adc_start_s = 1'b1;
            timer_s     = {TW{1'b0}};
            state_s     = CONVERT;
          end else begin
            settle_s = settle_r + SW'(1);
          end
        end

        CONVERT: begin
          // adc_done is tested first so it wins on the final timer cycle
          if (adc_done) begin
            px_data_s  = adc_data;
            px_row_s   = row_r;
            px_valid_s = 1'b1;
            state_s    = OUTPUT;
          end else if (timer_r == TIMER_LAST) begin
            timeout_err_s = 1'b1;
            nre_s         = ALL_HIGH;
            frame_done_s  = 1'b1;
            frame_cnt_s   = frame_cnt + 8'd1;
            state_s       = DONE;
          end else begin
            timer_s = timer_r + TW'(1);
          end
        end

        OUTPUT: begin
          if (px_ready) begin
            px_valid_s = 1'b0;
            nre_s      = ALL_HIGH;
            state_s    = GAP;
          end else begin
            state_s = OUTPUT;
          end
        end

        GAP: begin
          if (row_r == ROW_LAST) begin
            frame_done_s = 1'b1;
            frame_cnt_s  = frame_cnt + 8'd1;
            state_s      = DONE;
          end else begin
            row_s    = row_r + RW'(1);
            settle_s = {SW{1'b0}};
            nre_s    = row_select(row_r + RW'(1));
            state_s  = SELECT;
          end
        end

        DONE: begin
          // frame_done was raised on entry and drops back to 0 here
          state_s = IDLE;
        end

        default: begin
          state_s    = IDLE;
          nre_s      = ALL_HIGH;
          px_valid_s = 1'b0;
        end
      endcase
    end
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      row_r       <= {RW{1'b0}};
      settle_r    <= {SW{1'b0}};
      timer_r     <= {TW{1'b0}};
      nre         <= ALL_HIGH;
      adc_start   <= 1'b0;
      px_valid    <= 1'b0;
      px_data     <= {DW{1'b0}};
      px_row      <= {RW{1'b0}};
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
      frame_cnt   <= 8'd0;
    end else begin
      state_r     <= state_s;
      row_r       <= row_s;
      settle_r    <= settle_s;
      timer_r     <= timer_s;
      nre         <= nre_s;
      adc_start   <= adc_start_s;
      px_valid    <= px_valid_s;
      px_data     <= px_data_s;
      px_row      <= px_row_s;
      frame_done  <= frame_done_s;
      timeout_err <= timeout_err_s;
      frame_cnt   <= frame_cnt_s;
    end
  end

endmodule

// File: tb/tb_readout_scheduler.sv
// -----------------------------------------------------------------------------
// tb_readout_scheduler
//
// Directed bench for readout_scheduler at default parameters (ROWS=2, DW=4,
// SETTLE=1, TIMEOUT=15). Inputs change 1 time unit after each rising edge and
// outputs are sampled at that same point. This lets the edge numbering from
// the start-sampling edge be checked step by step against hand-computed values.
// -----------------------------------------------------------------------------
module tb_readout_scheduler;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [1:0] nre;
  logic       adc_start;
  logic       adc_done;
  logic [3:0] adc_data;
  logic       px_valid;
  logic       px_ready;
  logic [3:0] px_data;
  logic [0:0] px_row;
  logic       busy;
  logic       frame_done;
  logic       timeout_err;
  logic [7:0] frame_cnt;

  int vectors;
  int miscompares;

  readout_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .nre         (nre),
    .adc_start   (adc_start),
    .adc_done    (adc_done),
    .adc_data    (adc_data),
    .px_valid    (px_valid),
    .px_ready    (px_ready),
    .px_data     (px_data),
    .px_row      (px_row),
    .busy        (busy),
    .frame_done  (frame_done),
    .timeout_err (timeout_err),
    .frame_cnt   (frame_cnt)
  );

  // 10-unit clock period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance past the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // nominal two-row frame with px_ready high; the edge-8 frame_done is checked
  task automatic quick_frame(input logic [3:0] d0, input logic [3:0] d1);
    start = 1'b1;
    tick();                       // e0
    start = 1'b0;
    tick();                       // e1 adc_start
    adc_done = 1'b1; adc_data = d0;
    tick();                       // e2 px_valid
    adc_done = 1'b0;
    tick();                       // e3 GAP
    tick();                       // e4 row 1 select
    tick();                       // e5 adc_start
    adc_done = 1'b1; adc_data = d1;
    tick();                       // e6 px_valid
    adc_done = 1'b0;
    tick();                       // e7 GAP
    tick();                       // e8 DONE
    check("qf_frame_done", {31'd0, frame_done}, 32'd1);
    tick();                       // e9 IDLE
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset    = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    adc_done = 1'b0;
    adc_data = 4'h0;
    px_ready = 1'b1;

    // ---------------- reset state ----------------
    repeat (2) tick();
    check("rst_nre",        {30'd0, nre},         32'h3);
    check("rst_adc_start",  {31'd0, adc_start},   32'h0);
    check("rst_px_valid",   {31'd0, px_valid},    32'h0);
    check("rst_px_data",    {28'd0, px_data},     32'h0);
    check("rst_frame_cnt",  {24'd0, frame_cnt},   32'h0);
    check("rst_busy",       {31'd0, busy},        32'h0);
    check("rst_timeout",    {31'd0, timeout_err}, 32'h0);
    reset = 1'b0;
    tick();

    // ---------------- nominal frame: (row0,3) then (row1,C) ----------------
    start = 1'b1;
    tick();                                           // e0
    start = 1'b0;
    check("nom_e0_nre",  {30'd0, nre},  32'h2);
    check("nom_e0_busy", {31'd0, busy}, 32'h1);
    tick();                                           // e1
    check("nom_e1_adc_start", {31'd0, adc_start}, 32'h1);
    adc_done = 1'b1; adc_data = 4'h3;
    tick();                                           // e2
    adc_done = 1'b0;
    check("nom_e2_adc_start", {31'd0, adc_start}, 32'h0);
    check("nom_e2_px_valid",  {31'd0, px_valid},  32'h1);
    check("nom_e2_px_data",   {28'd0, px_data},   32'h3);
    check("nom_e2_px_row",    {31'd0, px_row},    32'h0);
    tick();                                           // e3 GAP
    check("nom_e3_nre",      {30'd0, nre},      32'h3);
    check("nom_e3_px_valid", {31'd0, px_valid}, 32'h0);
    tick();                                           // e4
    check("nom_e4_nre", {30'd0, nre}, 32'h1);
    tick();                                           // e5
    check("nom_e5_adc_start", {31'd0, adc_start}, 32'h1);
    adc_done = 1'b1; adc_data = 4'hC;
    tick();                                           // e6
    adc_done = 1'b0;
    check("nom_e6_px_valid", {31'd0, px_valid}, 32'h1);
    check("nom_e6_px_data",  {28'd0, px_data},  32'hC);
    check("nom_e6_px_row",   {31'd0, px_row},   32'h1);
    tick();                                           // e7 GAP
    check("nom_e7_nre", {30'd0, nre}, 32'h3);
    check("nom_e7_frame_done", {31'd0, frame_done}, 32'h0);
    tick();                                           // e8 DONE
    check("nom_e8_frame_done", {31'd0, frame_done},  32'h1);
    check("nom_e8_frame_cnt",  {24'd0, frame_cnt},   32'h1);
    check("nom_e8_timeout",    {31'd0, timeout_err}, 32'h0);
    tick();                                           // e9 IDLE
    check("nom_e9_busy",       {31'd0, busy},       32'h0);
    check("nom_e9_frame_done", {31'd0, frame_done}, 32'h0);

    // ---------------- backpressure on row 0 ----------------
    px_ready = 1'b0;
    start = 1'b1;
    tick();                                           // e0
    start = 1'b0;
    tick();                                           // e1
    adc_done = 1'b1; adc_data = 4'h5;
    tick();                                           // e2 OUTPUT
    adc_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_px_valid", {31'd0, px_valid}, 32'h1);
      check("bp_px_data",  {28'd0, px_data},  32'h5);
      check("bp_nre",      {30'd0, nre},      32'h2);
    end
    px_ready = 1'b1;
    tick();                                           // GAP
    check("bp_gap_px_valid", {31'd0, px_valid}, 32'h0);
    check("bp_gap_nre",      {30'd0, nre},      32'h3);
    tick();                                           // row 1 select
    check("bp_row1_nre", {30'd0, nre}, 32'h1);
    tick();                                           // adc_start
    adc_done = 1'b1; adc_data = 4'h6;
    tick();                                           // OUTPUT
    adc_done = 1'b0;
    check("bp_row1_px_data", {28'd0, px_data}, 32'h6);
    tick();                                           // GAP
    tick();                                           // DONE
    check("bp_frame_done", {31'd0, frame_done}, 32'h1);
    check("bp_frame_cnt",  {24'd0, frame_cnt},  32'h2);
    tick();                                           // IDLE

    // ---------------- ADC timeout: 15 CONVERT cycles ----------------
    start = 1'b1;
    tick();                                           // e0
    start = 1'b0;
    tick();                                           // e1 enter CONVERT
    for (int i = 0; i < 14; i++) begin               // e2..e15
      tick();
      check("to_px_valid", {31'd0, px_valid},    32'h0);
      check("to_pending",  {31'd0, timeout_err}, 32'h0);
    end
    tick();                                           // e16
    check("to_err",        {31'd0, timeout_err}, 32'h1);
    check("to_nre",        {30'd0, nre},         32'h3);
    check("to_frame_done", {31'd0, frame_done},  32'h1);
    check("to_frame_cnt",  {24'd0, frame_cnt},   32'h3);
    check("to_px_valid_e", {31'd0, px_valid},    32'h0);
    tick();
    check("to_idle_busy",  {31'd0, busy},        32'h0);
    check("to_sticky",     {31'd0, timeout_err}, 32'h1);

    // ---------------- next start clears it; adc_done on final cycle ----------------
    start = 1'b1;
    tick();                                           // e0
    start = 1'b0;
    check("lt_clear_err", {31'd0, timeout_err}, 32'h0);
    tick();                                           // e1
    repeat (14) tick();                               // e2..e15, timer now 14
    check("lt_wait_px_valid", {31'd0, px_valid}, 32'h0);
    adc_done = 1'b1; adc_data = 4'h9;
    tick();                                           // e16
    adc_done = 1'b0;
    check("lt_px_valid", {31'd0, px_valid},    32'h1);
    check("lt_px_data",  {28'd0, px_data},     32'h9);
    check("lt_err",      {31'd0, timeout_err}, 32'h0);
    tick();                                           // GAP
    tick();                                           // row 1 SELECT
    check("lt_row1_nre", {30'd0, nre}, 32'h1);

    // ---------------- abort during row 1 SELECT ----------------
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_busy",       {31'd0, busy},       32'h0);
    check("ab_nre",        {30'd0, nre},        32'h3);
    check("ab_adc_start",  {31'd0, adc_start},  32'h0);
    check("ab_frame_done", {31'd0, frame_done}, 32'h0);
    check("ab_frame_cnt",  {24'd0, frame_cnt},  32'h3);
    tick();
    check("ab_no_late_done", {31'd0, frame_done}, 32'h0);

    // start together with abort in IDLE is ignored
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("sa_busy", {31'd0, busy}, 32'h0);
    check("sa_nre",  {30'd0, nre},  32'h3);
    tick();
    check("sa_still_idle", {31'd0, busy}, 32'h0);

    // ---------------- async reset mid-CONVERT ----------------
    start = 1'b1;
    tick();                                           // e0
    start = 1'b0;
    tick();                                           // e1 CONVERT, adc_start high
    check("ar_pre_adc_start", {31'd0, adc_start}, 32'h1);
    #2;
    reset = 1'b1;
    #1;                                               // still before the next edge
    check("ar_nre",        {30'd0, nre},        32'h3);
    check("ar_adc_start",  {31'd0, adc_start},  32'h0);
    check("ar_busy",       {31'd0, busy},       32'h0);
    check("ar_px_data",    {28'd0, px_data},    32'h0);
    check("ar_frame_cnt",  {24'd0, frame_cnt},  32'h0);
    tick();
    reset = 1'b0;
    tick();

    // ---------------- 256 frames wrap frame_cnt ----------------
    for (int f = 0; f < 255; f++) begin
      quick_frame(4'(f), 4'(f + 1));
    end
    check("wrap_255", {24'd0, frame_cnt}, 32'd255);
    quick_frame(4'hA, 4'h5);
    check("wrap_0",   {24'd0, frame_cnt}, 32'd0);
    check("wrap_err", {31'd0, timeout_err}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
